inst_fifo: RTL and testbench

- Circular instruction buffer between the fetch unit and the ID stage.
- Absorbs fetched {inst, pc} pairs and presents the head entry to ID combinationally from registered storage.
- Pops when ID asserts its enable; the whole queue is discarded on a pipeline flush (branch mispredict / ROB clear).
- Provides early back-pressure to fetch and a sticky overflow flag for verification.

---
 rtl/inst_fifo.sv | 90 +++++++++
 tb/tb_inst_fifo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fifo.sv
// Circular instruction buffer between fetch and ID: registered {inst, pc} storage,
// head presented combinationally from registers, flush-able, with early fetch back-pressure.
module inst_fifo #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int FULL_MARGIN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              fetch_valid,
  input  logic [31:0]       fetch_inst,
  input  logic [31:0]       fetch_pc,
  output logic              fetch_stall,
  input  logic              id_enable,
  output logic              queue_is_empty,
  output logic [31:0]       head_inst,
  output logic [31:0]       head_pc,
  output logic [ADDR_W:0]   count,
  output logic              overflow_err
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] STALL_CNT = (ADDR_W+1)'(DEPTH - FULL_MARGIN);

  entry_t            mem_q [DEPTH];
  entry_t            head_e;
  logic [ADDR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              active, push_ok, pop_ok;

  always_comb begin
    active  = rdy & ~clear;
    push_ok = active & fetch_valid & (cnt_q != FULL_CNT);
    pop_ok  = active & id_enable & (cnt_q != '0);
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    // Flush wins over any same-cycle push/pop; the sticky overflow flag survives it.
    if (rdy & clear) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_ok) tail_d = tail_q + 1'b1;
      if (pop_ok)  head_d = head_q + 1'b1;
      if (push_ok & ~pop_ok)      cnt_d = cnt_q + 1'b1;
      else if (pop_ok & ~push_ok) cnt_d = cnt_q - 1'b1;
      if (active & fetch_valid & ~push_ok) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage needs no reset: it is only observable through head when cnt != 0.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[tail_q] <= '{inst: fetch_inst, pc: fetch_pc};
  end

  always_comb begin
    head_e         = mem_q[head_q];
    queue_is_empty = (cnt_q == '0);
    head_inst      = queue_is_empty ? 32'h0 : head_e.inst;
    head_pc        = queue_is_empty ? 32'h0 : head_e.pc;
    count          = cnt_q;
    fetch_stall    = (cnt_q >= STALL_CNT);
    overflow_err   = ovf_q;
  end

endmodule

// File: tb/tb_inst_fifo.sv
// Bench for inst_fifo: directed scenarios plus randomized traffic against a queue-based model.
module tb_inst_fifo;
  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  localparam int FULL_MARGIN = 1;

  logic clk = 1'b0;
  logic rst, rdy_i, clr, fv, id_en;
  logic [31:0] inst_i, pc_i;
  logic fetch_stall, queue_is_empty, overflow_err;
  logic [31:0] head_inst, head_pc;
  logic [ADDR_W:0] count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  ent_t mq[$];
  bit m_ovf;

  inst_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .FULL_MARGIN(FULL_MARGIN)) dut (
    .clk(clk), .rst(rst), .rdy(rdy_i), .clear(clr),
    .fetch_valid(fv), .fetch_inst(inst_i), .fetch_pc(pc_i),
    .fetch_stall(fetch_stall), .id_enable(id_en),
    .queue_is_empty(queue_is_empty), .head_inst(head_inst), .head_pc(head_pc),
    .count(count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // Advance one clock and apply the same request to the reference queue.
  task automatic step();
    int c;
    c = mq.size();
    @(posedge clk);
    if (rdy_i) begin
      if (clr) mq.delete();
      else begin
        if (fv && c == DEPTH) m_ovf = 1'b1;
        if (id_en && c != 0) void'(mq.pop_front());
        if (fv && c != DEPTH) mq.push_back('{inst: inst_i, pc: pc_i});
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    rdy_i = 1'b1; clr = 1'b0; fv = 1'b0; id_en = 1'b0; inst_i = '0; pc_i = '0;
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc);
    fv = 1'b1; inst_i = inst; pc_i = pc; step(); fv = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (queue_is_empty !== 1'b1 || count !== '0 || head_inst !== 32'h0 || head_pc !== 32'h0 || fetch_stall !== 1'b0 || overflow_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_hold: empty=%b count=%0d inst=%h pc=%h stall=%b ovf=%b", queue_is_empty, count, head_inst, head_pc, fetch_stall, overflow_err);
    end
    rst = 1'b1; mq.delete(); m_ovf = 1'b0;
    step();
    vectors++; if (queue_is_empty !== 1'b1 || count !== '0 || head_inst !== 32'h0 || fetch_stall !== 1'b0 || overflow_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_idle: empty=%b count=%0d inst=%h stall=%b ovf=%b", queue_is_empty, count, head_inst, fetch_stall, overflow_err);
    end
  endtask

  task automatic test_single();
    push(32'h00500093, 32'h0);
    vectors++; if (queue_is_empty !== 1'b0 || head_inst !== 32'h00500093 || head_pc !== 32'h0 || count !== 5'd1) begin
      miscompares++; $display("FAIL single_push: empty=%b inst=%h pc=%h count=%0d exp 0/00500093/0/1", queue_is_empty, head_inst, head_pc, count);
    end
    id_en = 1'b1; step(); id_en = 1'b0;
    vectors++; if (queue_is_empty !== 1'b1 || count !== '0 || head_inst !== 32'h0) begin
      miscompares++; $display("FAIL single_pop: empty=%b count=%0d inst=%h exp 1/0/0", queue_is_empty, count, head_inst);
    end
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < 16; i++) begin
      push($urandom, 32'(4 * i));
      vectors++; if (fetch_stall !== ((i + 1) >= 15)) begin
        miscompares++; $display("FAIL fill_stall[%0d]: got %b exp %b", i + 1, fetch_stall, ((i + 1) >= 15));
      end
    end
    vectors++; if (count !== 5'd16) begin
      miscompares++; $display("FAIL fill_count: got %0d exp 16", count);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++; if (head_pc !== 32'(4 * k)) begin
        miscompares++; $display("FAIL wrap_pop[%0d]: got %h exp %h", k, head_pc, 32'(4 * k));
      end
      id_en = 1'b1; step(); id_en = 1'b0;
    end
    for (int k = 0; k < 4; k++) push($urandom, 32'(64 + 4 * k));
    for (int k = 0; k < 16; k++) begin
      vectors++; if (head_pc !== 32'(16 + 4 * k) || head_inst !== mq[0].inst) begin
        miscompares++; $display("FAIL wrap_drain[%0d]: pc %h inst %h exp %h %h", k, head_pc, head_inst, 32'(16 + 4 * k), mq[0].inst);
      end
      id_en = 1'b1; step(); id_en = 1'b0;
    end
    vectors++; if (queue_is_empty !== 1'b1) begin
      miscompares++; $display("FAIL wrap_empty: got %b exp 1", queue_is_empty);
    end
  endtask

  task automatic test_simul();
    for (int i = 0; i < 5; i++) push($urandom, 32'h100 + 32'(4 * i));
    for (int k = 0; k < 10; k++) begin
      fv = 1'b1; id_en = 1'b1; inst_i = $urandom; pc_i = 32'h114 + 32'(4 * k);
      step();
      vectors++; if (count !== 5'd5 || head_pc !== 32'h100 + 32'(4 * (k + 1))) begin
        miscompares++; $display("FAIL simul[%0d]: count %0d pc %h exp 5 %h", k, count, head_pc, 32'h100 + 32'(4 * (k + 1)));
      end
    end
    fv = 1'b0;
    repeat (5) step();
    id_en = 1'b0;
    vectors++; if (count !== '0) begin
      miscompares++; $display("FAIL simul_drain: count %0d exp 0", count);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) push($urandom, 32'h2000 + 32'(4 * i));
    push(32'h12345678, 32'hDEAD0000);
    vectors++; if (overflow_err !== 1'b1 || count !== 5'd16) begin
      miscompares++; $display("FAIL overflow: ovf %b count %0d exp 1 16", overflow_err, count);
    end
    for (int k = 0; k < 16; k++) begin
      vectors++; if (head_pc === 32'hDEAD0000 || head_pc !== 32'h2000 + 32'(4 * k)) begin
        miscompares++; $display("FAIL ovf_drain[%0d]: pc %h exp %h", k, head_pc, 32'h2000 + 32'(4 * k));
      end
      id_en = 1'b1; step(); id_en = 1'b0;
    end
    vectors++; if (queue_is_empty !== 1'b1 || overflow_err !== 1'b1) begin
      miscompares++; $display("FAIL ovf_sticky: empty %b ovf %b exp 1 1", queue_is_empty, overflow_err);
    end
  endtask

  task automatic test_flush_rdy();
    logic [31:0] hp;
    for (int i = 0; i < 7; i++) push($urandom, 32'h3000 + 32'(4 * i));
    clr = 1'b1; fv = 1'b1; id_en = 1'b1; step(); clr = 1'b0; fv = 1'b0; id_en = 1'b0;
    vectors++; if (count !== '0 || queue_is_empty !== 1'b1 || overflow_err !== 1'b1) begin
      miscompares++; $display("FAIL flush: count %0d empty %b ovf %b exp 0 1 1", count, queue_is_empty, overflow_err);
    end
    for (int i = 0; i < 3; i++) push($urandom, 32'h4000 + 32'(4 * i));
    hp = head_pc;
    rdy_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      fv = 1'b1; id_en = 1'b1; clr = (k == 2); pc_i = 32'hBAD0 + 32'(k);
      step();
      vectors++; if (count !== 5'd3 || head_pc !== 32'h4000 || hp !== 32'h4000) begin
        miscompares++; $display("FAIL rdy_stall[%0d]: count %0d pc %h exp 3 00004000", k, count, head_pc);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    bit fill;
    for (int n = 0; n < 2000; n++) begin
      fill   = ((n / 150) % 2) == 0;
      rdy_i  = ($urandom_range(0, 9) != 0);
      clr    = ($urandom_range(0, 59) == 0);
      fv     = ($urandom_range(0, 99) < (fill ? 85 : 30));
      id_en  = ($urandom_range(0, 99) < (fill ? 30 : 85));
      inst_i = $urandom; pc_i = $urandom;
      step();
      vectors++; if (count !== (ADDR_W+1)'(mq.size()) || queue_is_empty !== (mq.size() == 0)) begin
        miscompares++; $display("FAIL rand_count[%0d]: count %0d empty %b exp %0d", n, count, queue_is_empty, mq.size());
      end
      vectors++; if (head_pc !== (mq.size() ? mq[0].pc : 32'h0) || head_inst !== (mq.size() ? mq[0].inst : 32'h0)) begin
        miscompares++; $display("FAIL rand_head[%0d]: pc %h inst %h exp %h %h", n, head_pc, head_inst, mq.size() ? mq[0].pc : 32'h0, mq.size() ? mq[0].inst : 32'h0);
      end
      vectors++; if (fetch_stall !== (mq.size() >= DEPTH - FULL_MARGIN) || overflow_err !== m_ovf) begin
        miscompares++; $display("FAIL rand_flags[%0d]: stall %b ovf %b exp %b %b", n, fetch_stall, overflow_err, (mq.size() >= DEPTH - FULL_MARGIN), m_ovf);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_wrap();
    test_simul();
    test_overflow();
    test_flush_rdy();
    test_random();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
